// File: rtl/down_counter_timer_pkg.sv
// ----------------------------------------------------------------------------
// down_counter_timer_pkg
//   Shared definitions for the loadable down-counting timer.
//   - state_t       : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   - DEFAULT_WIDTH : default count width
//   - state_busy    : decode of the "busy" condition (RUN or PAUSE)
// ----------------------------------------------------------------------------
package down_counter_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic state_busy(input state_t s);
        return (s == S_RUN) || (s == S_PAUSE);
    endfunction

endpackage

// File: rtl/down_counter_timer_core.sv
// ----------------------------------------------------------------------------
// down_counter_core
//   WIDTH-bit count register with load / decrement / hold.
//   Ports:
//     clk      : rising-edge clock
//     clr_n    : asynchronous active-low reset (count -> 0)
//     load     : capture load_val (wins over dec)
//     load_val : value to load
//     dec      : decrement by one; ignored at zero so the count never wraps
//     count    : current count (registered)
//     is_one   : count == 1, the terminal step for the controlling FSM
// ----------------------------------------------------------------------------
module down_counter_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/down_counter_timer.sv
// ----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down-counting timer with one-shot / auto-reload modes,
//   pause/resume and abort. Emits a one-cycle tc pulse on terminal count.
//   Ports:
//     clk      : rising-edge clock
//     clr_n    : asynchronous active-low reset
//     load     : capture load_val into reload register and count (IDLE/DONE)
//     load_val : reload value
//     start    : IDLE/DONE -> RUN, PAUSE -> RUN (resume)
//     stop     : RUN -> PAUSE
//     abort    : any state -> IDLE, count <= reload register
//     auto_rl  : 1 = reload on terminal count, 0 = one-shot (sampled at tc)
//     tick     : decrement enable
//     count    : current count
//     tc       : registered terminal-count pulse
//     busy     : RUN or PAUSE
//     done     : DONE
//   Edge priority: abort > stop > start > load > tick.
// ----------------------------------------------------------------------------
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             auto_rl,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_r, reload_nxt;
    logic             tc_nxt;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_is_one;

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (count),
        .is_one   (cnt_is_one)
    );

    // Next-state decode also drives the count core, so the core and the
    // FSM registers always act on the same priority resolution.
    always_comb begin
        state_nxt  = state;
        reload_nxt = reload_r;
        tc_nxt     = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = reload_r;
        cnt_dec    = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            cnt_load  = 1'b1;
            cnt_val   = reload_r;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // A coincident load is dropped: start runs on the
                        // reload value held before this edge.
                        cnt_load = 1'b1;
                        cnt_val  = reload_r;
                        if (reload_r == '0) begin
                            state_nxt = S_DONE;
                            tc_nxt    = 1'b1;
                        end else begin
                            state_nxt = S_RUN;
                        end
                    end else if (load) begin
                        reload_nxt = load_val;
                        cnt_load   = 1'b1;
                        cnt_val    = load_val;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_nxt = S_PAUSE;
                    end else if (tick) begin
                        if (cnt_is_one) begin
                            tc_nxt   = 1'b1;
                            cnt_load = 1'b1;
                            if (auto_rl) begin
                                cnt_val = reload_r;
                            end else begin
                                cnt_val   = '0;
                                state_nxt = S_DONE;
                            end
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= S_IDLE;
            reload_r <= '0;
            tc       <= 1'b0;
        end else begin
            state    <= state_nxt;
            reload_r <= reload_nxt;
            tc       <= tc_nxt;
        end
    end

    assign busy = state_busy(state);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// ----------------------------------------------------------------------------
// tb_down_counter_timer
//   Directed, table-driven bench for down_counter_timer (WIDTH = 8).
// ----------------------------------------------------------------------------
module tb_down_counter_timer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         clr_n;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         abort;
    logic         auto_rl;
    logic         tick;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    int errors;
    int checks;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         sp;
        logic         ab;
        logic         ar;
        logic         tk;
        logic [W-1:0] e_cnt;
        logic         e_tc;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t vecs[$];

    down_counter_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .abort    (abort),
        .auto_rl  (auto_rl),
        .tick     (tick),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [W-1:0] lv,
                                input logic st, input logic sp, input logic ab,
                                input logic ar, input logic tk,
                                input logic [W-1:0] e_cnt, input logic e_tc,
                                input logic e_busy, input logic e_done);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ab = ab; v.ar = ar; v.tk = tk;
        v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] e_cnt,
                         input logic e_tc, input logic e_busy, input logic e_done);
        checks++;
        if (count !== e_cnt || tc !== e_tc || busy !== e_busy || done !== e_done) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                     name, count, tc, busy, done, e_cnt, e_tc, e_busy, e_done);
        end
    endtask

    task automatic drive_idle();
        load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        abort = 1'b0; auto_rl = 1'b0; tick = 1'b0;
    endtask

    // Inputs set on the falling edge, outputs sampled 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        load = v.ld; load_val = v.lv; start = v.st; stop = v.sp;
        abort = v.ab; auto_rl = v.ar; tick = v.tk;
        @(posedge clk);
        #1;
        check(name, v.e_cnt, v.e_tc, v.e_busy, v.e_done);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive_idle();
        clr_n = 1'b0;

        //                 ld lv   st sp ab ar tk   cnt tc b  d
        // one-shot, load 4
        vecs.push_back(mk(1, 4,   0, 0, 0, 0, 0,   4,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 1,   4,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   3,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   2,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   1,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   0,  1, 0, 1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   0,  0, 0, 1));
        // auto-reload, period 3, loaded from DONE
        vecs.push_back(mk(1, 3,   0, 0, 0, 0, 0,   3,  0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 0, 0, 1, 1,   3,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   2,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   1,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   3,  1, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   2,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   1,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   3,  1, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 1, 1, 1,   3,  0, 0, 0));
        // pause / resume
        vecs.push_back(mk(1, 6,   0, 0, 0, 0, 0,   6,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 1,   6,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   5,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   4,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0, 1,   4,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   4,  0, 1, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 1,   4,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   3,  0, 1, 0));
        // abort, reload 9, tick gaps, load ignored in RUN
        vecs.push_back(mk(0, 0,   0, 0, 1, 0, 0,   6,  0, 0, 0));
        vecs.push_back(mk(1, 9,   0, 0, 0, 0, 0,   9,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 0,   9,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,   9,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   8,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   7,  0, 1, 0));
        vecs.push_back(mk(1, 5,   0, 0, 0, 0, 0,   7,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   6,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   5,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   4,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   3,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   2,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 1, 0, 1,   9,  0, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   9,  0, 0, 0));
        // zero reload: start gives a single tc and stays DONE
        vecs.push_back(mk(1, 0,   0, 0, 0, 0, 0,   0,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 0,   0,  1, 0, 1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,   0,  0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 1,   0,  1, 0, 1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   0,  0, 0, 1));
        // load + start same edge: start sees the old reload value
        vecs.push_back(mk(1, 7,   1, 0, 0, 0, 0,   0,  1, 0, 1));
        vecs.push_back(mk(1, 2,   0, 0, 0, 0, 0,   2,  0, 0, 1));
        vecs.push_back(mk(1, 5,   1, 0, 0, 0, 1,   2,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   1,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   0,  1, 0, 1));
        // reload 1, auto: back-to-back tc; one-shot sampled at tc
        vecs.push_back(mk(1, 1,   0, 0, 0, 0, 0,   1,  0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 0, 0, 1, 1,   1,  0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   1,  1, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1, 1,   1,  1, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   0,  1, 0, 1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   0,  0, 0, 1));
        // full-scale value
        vecs.push_back(mk(1, 255, 0, 0, 0, 0, 0,   255, 0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0, 1,   255, 0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 1,   254, 0, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 1, 0, 0,   255, 0, 0, 0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 0, 0, 0, 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // async reset mid-RUN with count 5
        apply(mk(1, 5, 0, 0, 0, 0, 0, 5, 0, 0, 0), "rst_load5");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 5, 0, 1, 0), "rst_start");
        @(negedge clk);
        drive_idle();
        #2;
        clr_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        clr_n = 1'b1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        check("no_tc_after_reset", 0, 0, 0, 0);
        // reload register cleared by reset: start goes straight to DONE with tc
        apply(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1), "post_reset_start");

        @(negedge clk);
        drive_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
